// File: rtl/cvt_pkt_buf_pkg.sv
// Shared types and constants for the cvt_pkt_buf packet buffer.
package cvt_pkt_buf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RECV = 3'd1,
        ST_PROC = 3'd2,
        ST_SEND = 3'd3,
        ST_DROP = 3'd4
    } state_e;

    localparam int unsigned DROP_CNT_W = 16;

    // Buffer words are packed {ctrl, data}: the ctrl field sits directly above data.
    function automatic int unsigned word_w(input int unsigned data_w, input int unsigned ctrl_w);
        return data_w + ctrl_w;
    endfunction

    function automatic int unsigned ctrl_lsb(input int unsigned data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/cvt_pkt_buf_if.sv
// Packet-in, packet-out, processor and status signals of cvt_pkt_buf.
// drop_cnt exists only when CVT_PKT_BUF_DROP_EN is defined.
interface cvt_pkt_buf_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned ADDR_W = 8
);
    import cvt_pkt_buf_pkg::*;

    logic [DATA_W-1:0]        in_data;
    logic [CTRL_W-1:0]        in_ctrl;
    logic                     in_wr;
    logic                     in_eop;
    logic                     in_rdy;

    logic [DATA_W-1:0]        out_data;
    logic [CTRL_W-1:0]        out_ctrl;
    logic                     out_wr;
    logic                     out_rdy;

    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W+CTRL_W-1:0] mem_wdata;
    logic                     mem_we;
    logic [DATA_W+CTRL_W-1:0] mem_rdata;

    logic                     proc_done;
    logic                     pkt_ready;
    logic [ADDR_W:0]          pkt_len;
`ifdef CVT_PKT_BUF_DROP_EN
    logic [DROP_CNT_W-1:0]    drop_cnt;
`endif

    modport master (
`ifdef CVT_PKT_BUF_DROP_EN
        input  drop_cnt,
`endif
        output in_data, in_ctrl, in_wr, in_eop, out_rdy,
        output mem_addr, mem_wdata, mem_we, proc_done,
        input  in_rdy, out_data, out_ctrl, out_wr, mem_rdata, pkt_ready, pkt_len
    );

    modport slave (
`ifdef CVT_PKT_BUF_DROP_EN
        output drop_cnt,
`endif
        input  in_data, in_ctrl, in_wr, in_eop, out_rdy,
        input  mem_addr, mem_wdata, mem_we, proc_done,
        output in_rdy, out_data, out_ctrl, out_wr, mem_rdata, pkt_ready, pkt_len
    );

endinterface

// File: rtl/cvt_dp_ram.sv
// True dual-port RAM with registered (synchronous) reads; port A is write-first.
module cvt_dp_ram #(
    parameter int unsigned WORD_W = 72,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_a_i,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [WORD_W-1:0] wdata_a_i,
    output logic [WORD_W-1:0] rdata_a_o,
    input  logic              en_b_i,
    input  logic              we_b_i,
    input  logic [ADDR_W-1:0] addr_b_i,
    input  logic [WORD_W-1:0] wdata_b_i,
    output logic [WORD_W-1:0] rdata_b_o
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_a_q;
    logic [WORD_W-1:0] rdata_b_q;

    // Storage array carries no reset so it maps onto RAM macros.
    always_ff @(posedge clk) begin
        if (en_a_i && we_a_i) mem_q[addr_a_i] <= wdata_a_i;
        if (en_b_i && we_b_i) mem_q[addr_b_i] <= wdata_b_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            if (en_a_i) rdata_a_q <= we_a_i ? wdata_a_i : mem_q[addr_a_i];
            if (en_b_i) rdata_b_q <= we_b_i ? wdata_b_i : mem_q[addr_b_i];
        end
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/cvt_pkt_buf.sv
// Store-process-forward packet buffer: receive a packet, hand it to a processor, then transmit it.
// Overflow policy: truncation by default, drop-and-count when CVT_PKT_BUF_DROP_EN is defined.
module cvt_pkt_buf
    import cvt_pkt_buf_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    cvt_pkt_buf_if.slave  pkt_if
);
    localparam int unsigned WORD_W   = word_w(DATA_W, CTRL_W);
    localparam int unsigned CTRL_LSB = ctrl_lsb(DATA_W);
    localparam int unsigned LEN_W    = ADDR_W + 1;
    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [LEN_W-1:0]  rptr_q, rptr_d;
    logic [LEN_W-1:0]  pkt_len_q, pkt_len_d;
    logic              out_vld_q, out_vld_d;
    logic              arm_q, arm_d;
    logic              in_rdy_q, in_rdy_d;
    logic              pkt_ready_q, pkt_ready_d;

    logic              accept;
    logic              at_last;
    logic              proc_we;
    logic              out_fire;
    logic              rd_load;
    logic              send_last;

    logic              ram_we_a;
    logic [ADDR_W-1:0] ram_addr_a;
    logic [WORD_W-1:0] ram_wdata_a;
    logic [WORD_W-1:0] ram_rdata_a;
    logic [WORD_W-1:0] ram_rdata_b;

`ifdef CVT_PKT_BUF_DROP_EN
    logic                  drop_inc;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
`endif

    assign accept   = pkt_if.in_wr & in_rdy_q;
    assign at_last  = (wptr_q == LAST_ADDR);
    assign proc_we  = pkt_if.mem_we & (state_q == ST_PROC);
    assign out_fire = out_vld_q & pkt_if.out_rdy;
    // arm_q holds off the first read one cycle after entering SEND.
    assign rd_load   = (state_q == ST_SEND) & arm_q & (rptr_q != pkt_len_q) & (~out_vld_q | out_fire);
    assign send_last = (state_q == ST_SEND) & out_fire & (rptr_q == pkt_len_q);

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        pkt_len_d   = pkt_len_q;
        out_vld_d   = out_vld_q;
        arm_d       = 1'b0;
        in_rdy_d    = 1'b0;
        pkt_ready_d = 1'b0;
`ifdef CVT_PKT_BUF_DROP_EN
        drop_inc    = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE, ST_RECV: begin
                if (accept) begin
                    wptr_d  = wptr_q + ADDR_W'(1);
                    state_d = ST_RECV;
                    if (pkt_if.in_eop) begin
                        pkt_len_d = LEN_W'(wptr_q) + LEN_W'(1);
                        wptr_d    = '0;
                        state_d   = ST_PROC;
                    end else if (at_last) begin
`ifdef CVT_PKT_BUF_DROP_EN
                        wptr_d    = '0;
                        state_d   = ST_DROP;
`else
                        pkt_len_d = LEN_W'(DEPTH);
                        wptr_d    = '0;
                        state_d   = ST_PROC;
`endif
                    end
                end
            end
            ST_PROC: begin
                if (pkt_if.proc_done) begin
                    state_d   = ST_SEND;
                    rptr_d    = '0;
                    out_vld_d = 1'b0;
                end
            end
            ST_SEND: begin
                arm_d = 1'b1;
                if (rd_load) begin
                    rptr_d    = rptr_q + LEN_W'(1);
                    out_vld_d = 1'b1;
                end else if (out_fire) begin
                    out_vld_d = 1'b0;
                end
                if (send_last) begin
                    state_d   = ST_IDLE;
                    rptr_d    = '0;
                    pkt_len_d = '0;
                    arm_d     = 1'b0;
                end
            end
            ST_DROP: begin
                if (accept && pkt_if.in_eop) begin
                    state_d = ST_IDLE;
`ifdef CVT_PKT_BUF_DROP_EN
                    drop_inc = 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_rdy_d    = (state_d == ST_IDLE) | (state_d == ST_RECV) | (state_d == ST_DROP);
        pkt_ready_d = (state_d == ST_PROC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            pkt_len_q   <= '0;
            out_vld_q   <= 1'b0;
            arm_q       <= 1'b0;
            in_rdy_q    <= 1'b0;
            pkt_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            pkt_len_q   <= pkt_len_d;
            out_vld_q   <= out_vld_d;
            arm_q       <= arm_d;
            in_rdy_q    <= in_rdy_d;
            pkt_ready_q <= pkt_ready_d;
        end
    end

`ifdef CVT_PKT_BUF_DROP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop_inc && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    assign pkt_if.drop_cnt = drop_cnt_q;
`endif

    // Port A serves inbound writes, otherwise the processor; words dropped in DROP are not stored.
    assign ram_we_a    = (accept & (state_q != ST_DROP)) | proc_we;
    assign ram_addr_a  = accept ? wptr_q : pkt_if.mem_addr;
    assign ram_wdata_a = accept ? {pkt_if.in_ctrl, pkt_if.in_data} : pkt_if.mem_wdata;

    cvt_dp_ram #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .en_a_i    (1'b1),
        .we_a_i    (ram_we_a),
        .addr_a_i  (ram_addr_a),
        .wdata_a_i (ram_wdata_a),
        .rdata_a_o (ram_rdata_a),
        .en_b_i    (rd_load),
        .we_b_i    (1'b0),
        .addr_b_i  (rptr_q[ADDR_W-1:0]),
        .wdata_b_i ('0),
        .rdata_b_o (ram_rdata_b)
    );

    assign pkt_if.in_rdy    = in_rdy_q;
    assign pkt_if.pkt_ready = pkt_ready_q;
    assign pkt_if.pkt_len   = pkt_len_q;
    assign pkt_if.mem_rdata = ram_rdata_a;
    assign pkt_if.out_data  = ram_rdata_b[DATA_W-1:0];
    assign pkt_if.out_ctrl  = ram_rdata_b[WORD_W-1:CTRL_LSB];
    // The held word is offered only in cycles the sink can take it.
    assign pkt_if.out_wr    = out_vld_q & pkt_if.out_rdy;

endmodule
